// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for a single-cycle core.
// Serves a word-addressed RAM and a small peripheral page (LED register,
// free-running cycle counter, compare timer with interrupt). Reads are
// combinational from the address so loads finish in one cycle. Writes
// commit on the rising clock edge.
module dmem_mmio_responder #(
    parameter int          N           = 32,
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
    parameter int          LED_W       = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      daddr,
    input  logic [N-1:0]     ddata_w,
    input  logic             d_rw,
    output logic [N-1:0]     ddata_r,
    output logic [LED_W-1:0] leds,
    output logic             irq
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    // Peripheral register slots, word offsets within the page
    localparam logic [2:0] REG_LED    = 3'd0;
    localparam logic [2:0] REG_CYCLE  = 3'd1;
    localparam logic [2:0] REG_CMP    = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;

    // RAM storage: no reset, contents persist across RESET
    logic [N-1:0] mem [DEPTH_WORDS];

    // Peripheral state
    logic [LED_W-1:0] led_q,   led_d;
    logic [N-1:0]     cycle_q, cycle_d;
    logic [N-1:0]     cmp_q,   cmp_d;
    logic [N-1:0]     count_q, count_d;
    logic [1:0]       ctrl_q,  ctrl_d;
    logic             flag_q,  flag_d;

    // Address decode; RAM is checked first so an overlapping page can never
    // shadow RAM words
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [2:0]    reg_sel;

    assign ram_hit  = (daddr < RAM_BYTES);
    assign mmio_hit = !ram_hit && (daddr[31:12] == MMIO_BASE[31:12]);
    assign ram_idx  = daddr[AW+1:2];
    assign reg_sel  = daddr[4:2];

    // Per-target write strobes
    logic wr_ram;
    logic wr_led;
    logic wr_cmp;
    logic wr_status;
    logic wr_count;
    logic wr_ctrl;
    logic match_evt;

    assign wr_ram    = d_rw && ram_hit;
    assign wr_led    = d_rw && mmio_hit && (reg_sel == REG_LED);
    assign wr_cmp    = d_rw && mmio_hit && (reg_sel == REG_CMP);
    assign wr_status = d_rw && mmio_hit && (reg_sel == REG_STATUS);
    assign wr_count  = d_rw && mmio_hit && (reg_sel == REG_COUNT);
    assign wr_ctrl   = d_rw && mmio_hit && (reg_sel == REG_CTRL);

    // A software COUNT write suppresses both the reload and the flag set;
    // the compare always uses the pre-edge CMP value
    assign match_evt = ctrl_q[0] && (count_q == cmp_q) && !wr_count;

    // Next-state for the peripheral registers
    always_comb begin
        led_d   = led_q;
        cycle_d = cycle_q + N'(1);
        cmp_d   = cmp_q;
        count_d = count_q;
        ctrl_d  = ctrl_q;
        flag_d  = flag_q;

        if (wr_led) begin
            led_d = ddata_w[LED_W-1:0];
        end
        if (wr_cmp) begin
            cmp_d = ddata_w;
        end
        if (wr_ctrl) begin
            ctrl_d = ddata_w[1:0];
        end

        if (wr_count) begin
            count_d = ddata_w;
        end else if (match_evt) begin
            count_d = '0;
        end else if (ctrl_q[0]) begin
            count_d = count_q + N'(1);
        end

        // Set beats write-1-to-clear when both land on the same edge
        if (match_evt) begin
            flag_d = 1'b1;
        end else if (wr_status && ddata_w[0]) begin
            flag_d = 1'b0;
        end
    end

    // Peripheral state registers with asynchronous reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            led_q   <= '0;
            cycle_q <= '0;
            cmp_q   <= '0;
            count_q <= '0;
            ctrl_q  <= '0;
            flag_q  <= 1'b0;
        end else begin
            led_q   <= led_d;
            cycle_q <= cycle_d;
            cmp_q   <= cmp_d;
            count_q <= count_d;
            ctrl_q  <= ctrl_d;
            flag_q  <= flag_d;
        end
    end

    // RAM write port; a write presented while RESET is high is dropped
    always_ff @(posedge CLK) begin
        if (wr_ram && !RESET) begin
            mem[ram_idx] <= ddata_w;
        end
    end

    // Combinational read mux; unmapped addresses and spare slots read zero
    always_comb begin
        ddata_r = '0;
        if (ram_hit) begin
            ddata_r = mem[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_LED:    ddata_r = {{(N-LED_W){1'b0}}, led_q};
                REG_CYCLE:  ddata_r = cycle_q;
                REG_CMP:    ddata_r = cmp_q;
                REG_STATUS: ddata_r = {{(N-1){1'b0}}, flag_q};
                REG_COUNT:  ddata_r = count_q;
                REG_CTRL:   ddata_r = {{(N-2){1'b0}}, ctrl_q};
                default:    ddata_r = '0;
            endcase
        end
    end

    assign leds = led_q;
    assign irq  = flag_q && ctrl_q[1];

endmodule
